inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS core: the requester side of the instruction-memory interface.
- Owns the PC and drives the instruction memory's chip-enable and byte-address.
- Captures the returned word (memory is combinational-read) into the IF/ID pipeline register.
- Handles redirects from the ID-stage branch, pipeline flush/exception, and per-stage stall from ctrl.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; low 2 bits must be 0.
- ADDR_W, `Inst_Addr (32), PC/address width.
- DATA_W, `Inst_Data (32), instruction width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  2  from ctrl; [0] holds PC, [1] holds IF/ID; ctrl guarantees stall[1] implies stall[0].
- flush  in  1  exception/eret flush from ctrl.
- new_pc  in  ADDR_W  flush target.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_i  in  ADDR_W  branch target.
- rom_ce  out  1  `Chip_Enable/`Chip_Disable to instruction memory.
- rom_addr  out  ADDR_W  byte address, equal to the current PC.
- rom_inst  in  DATA_W  combinational read data for rom_addr.
- id_pc  out  ADDR_W  registered PC for ID.
- id_inst  out  DATA_W  registered instruction for ID.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- State machine, 2 states.
  - BOOT (reset state): rom_ce=`Chip_Disable, pc=RESET_PC. Goes to RUN unconditionally on the first clk edge after rst deasserts.
  - RUN: rom_ce=`Chip_Enable. There is no way back to BOOT except reset.
- Reset (async, rst=0, any time including mid-fetch):
  - pc=RESET_PC, rom_ce=`Chip_Disable.
  - id_pc=`Zero_Word, id_inst=`Zero_Word, id_valid=0.
  - All take effect immediately, not on a clock edge.
- In BOOT:
  - pc stays at RESET_PC.
  - IF/ID loads a bubble (zeros, id_valid=0).
  - First real fetch is RESET_PC in the first RUN cycle.
- Next-PC in RUN, priority high to low:
  - flush: pc<=new_pc.
  - stall[0]: pc holds.
  - branch_flag_i: pc<=branch_target_i.
  - otherwise: pc<=pc+4. Modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- branch_flag_i is ignored while stall[0]=1; ID re-presents it after the stall releases.
- Branch delay slot: the instruction fetched in the cycle branch_flag_i is high is NOT squashed. It enters IF/ID with id_valid=1.
- IF/ID register update, priority:
  - flush: bubble.
  - stall[1]: hold.
  - stall[0] & !stall[1]: bubble.
  - rom_ce disabled: bubble.
  - otherwise: id_pc<=pc, id_inst<=rom_inst, id_valid<=1.
- Bubble means id_pc=`Zero_Word, id_inst=`Zero_Word (a MIPS NOP), id_valid=0.
- Latency: instruction at address A appears on id_inst one clock after rom_addr=A.
- Simultaneous events:
  - flush+stall: flush wins for both PC and IF/ID.
  - flush+branch: flush wins.
- Address alignment: the low 2 bits of branch_target_i/new_pc are masked to 0 before loading pc (default build).

Optional Feature:
- Macro: INST_FETCH_ADEL_EN.
- Enabled:
  - Adds output id_excp_adel (1 bit, registered with IF/ID, reset 0).
  - A misaligned branch_target_i/new_pc is loaded unmasked.
  - While pc[1:0]!=0: rom_ce is forced to `Chip_Disable, IF/ID loads id_pc=pc, id_inst=`Zero_Word, id_valid=1, id_excp_adel=1.
  - pc holds until flush.
- Disabled: masking as above; no extra port.

Decomposition:
- Shared define.v holds: `Inst_Addr, `Inst_Data, `Chip_Enable, `Chip_Disable, `Zero_Word.
- New entries in define.v:
  - `Stall_Width (2).
  - `Pc_Step (32'd4).
  - `Fetch_Boot / `Fetch_Run state encodings.
- One natural sub-module, pc_reg: state machine plus next-PC mux, drives rom_ce and rom_addr.
- The IF/ID register stays in inst_fetch.

Test Plan:
- Reset release, RESET_PC=0, memory word[i]=i+1:
  - rom_ce=0 for one cycle, then rom_addr 0,4,8,...
  - id_inst 1,2,3 on consecutive cycles; id_valid rises one cycle after rom_ce.
- Branch at pc=0x8, target 0x40:
  - Sequence at id_pc is 0x8, 0xC (delay slot, valid), 0x40, 0x44.
- stall=2'b01 for 2 cycles at pc=0x10:
  - rom_addr holds 0x10.
  - id_valid=0 for 2 cycles, then id_pc=0x10.
- stall=2'b11 for 3 cycles: id_pc/id_inst frozen, pc frozen. Then resume with no skipped or duplicated address.
- flush with new_pc=0x180, same cycle as branch_flag_i and stall=2'b11:
  - next rom_addr=0x180, IF/ID bubble.
- rst pulled low mid-run at pc=0x24:
  - outputs zero immediately, rom_ce=0.
  - After release, fetch restarts at RESET_PC.
- pc=0xFFFF_FFFC: next rom_addr=0x0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
// Optional misaligned-fetch exception support is selected with INST_FETCH_ADEL_EN.
package inst_fetch_pkg;

  localparam int INST_ADDR   = 32;
  localparam int INST_DATA   = 32;
  localparam int STALL_WIDTH = 2;

  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [0:0] {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory bus: the fetch stage is the master, the memory the slave.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;

  modport master (output rom_ce, output rom_addr, input rom_inst);
  modport slave  (input rom_ce, input rom_addr, output rom_inst);
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Fetch state machine and next-PC selection; drives the memory chip-enable and address.
// With INST_FETCH_ADEL_EN, misaligned targets are kept and a misaligned PC parks until flush.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      state_r, state_next_s;
  logic [ADDR_W-1:0] pc_r, pc_next_s;
  logic [ADDR_W-1:0] flush_target_s, branch_target_s;

`ifdef INST_FETCH_ADEL_EN
  assign flush_target_s  = new_pc;
  assign branch_target_s = branch_target;
`else
  assign flush_target_s  = {new_pc[ADDR_W-1:2], 2'b00};
  assign branch_target_s = {branch_target[ADDR_W-1:2], 2'b00};
`endif

  // State register: BOOT after reset, RUN forever after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= FETCH_BOOT;
    else      state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH_BOOT: state_next_s = FETCH_RUN;
      FETCH_RUN:  state_next_s = FETCH_RUN;
      default:    state_next_s = FETCH_BOOT;
    endcase
  end

  // Output decode: memory enabled only while running on an aligned PC.
  always_comb begin
    rom_ce = CHIP_DISABLE;
    case (state_r)
      FETCH_RUN: begin
`ifdef INST_FETCH_ADEL_EN
        if (is_misaligned(pc_r[1:0])) rom_ce = CHIP_DISABLE;
        else                          rom_ce = CHIP_ENABLE;
`else
        rom_ce = CHIP_ENABLE;
`endif
      end
      default: rom_ce = CHIP_DISABLE;
    endcase
  end

  // Next-PC mux: flush beats stall, stall beats branch, branch beats sequential.
  always_comb begin
    pc_next_s = pc_r;
    if (state_r != FETCH_RUN)              pc_next_s = RESET_PC;
    else if (flush)                        pc_next_s = flush_target_s;
    else if (hold_pc)                      pc_next_s = pc_r;
`ifdef INST_FETCH_ADEL_EN
    else if (is_misaligned(pc_r[1:0]))    pc_next_s = pc_r;
`endif
    else if (branch_flag)                  pc_next_s = branch_target_s;
    else                                   pc_next_s = pc_r + ADDR_W'(PC_STEP);
  end

  // PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_r <= RESET_PC;
    else      pc_r <= pc_next_s;
  end

  assign pc = pc_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC/memory requester plus the IF/ID pipeline register.
// Define INST_FETCH_ADEL_EN to raise id_excp_adel on misaligned fetch addresses.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR,
  parameter int                DATA_W   = INST_DATA,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      new_pc,
  input  logic                   branch_flag_i,
  input  logic [ADDR_W-1:0]      branch_target_i,
  inst_fetch_if.master           rom,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [DATA_W-1:0]      id_inst,
  output logic                   id_valid
`ifdef INST_FETCH_ADEL_EN
  ,
  output logic                   id_excp_adel
`endif
);

  logic              rom_ce_s;
  logic [ADDR_W-1:0] pc_s;
  logic [ADDR_W-1:0] id_pc_next_s;
  logic [DATA_W-1:0] id_inst_next_s;
  logic              id_valid_next_s;
  logic              id_adel_next_s;
  logic              id_adel_r;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .hold_pc       (stall[0]),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag_i),
    .branch_target (branch_target_i),
    .rom_ce        (rom_ce_s),
    .pc            (pc_s)
  );

  assign rom.rom_ce   = rom_ce_s;
  assign rom.rom_addr = pc_s;

  // IF/ID next value: flush, hold, stall bubble, idle bubble, then a real fetch.
  always_comb begin
    id_pc_next_s    = id_pc;
    id_inst_next_s  = id_inst;
    id_valid_next_s = id_valid;
    id_adel_next_s  = id_adel_r;
    if (flush || (stall[0] && !stall[1])) begin
      id_pc_next_s    = ADDR_W'(ZERO_WORD);
      id_inst_next_s  = DATA_W'(ZERO_WORD);
      id_valid_next_s = 1'b0;
      id_adel_next_s  = 1'b0;
    end else if (stall[1]) begin
      id_pc_next_s    = id_pc;
      id_inst_next_s  = id_inst;
      id_valid_next_s = id_valid;
      id_adel_next_s  = id_adel_r;
`ifdef INST_FETCH_ADEL_EN
    end else if (is_misaligned(pc_s[1:0])) begin
      id_pc_next_s    = pc_s;
      id_inst_next_s  = DATA_W'(ZERO_WORD);
      id_valid_next_s = 1'b1;
      id_adel_next_s  = 1'b1;
`endif
    end else if (rom_ce_s == CHIP_DISABLE) begin
      id_pc_next_s    = ADDR_W'(ZERO_WORD);
      id_inst_next_s  = DATA_W'(ZERO_WORD);
      id_valid_next_s = 1'b0;
      id_adel_next_s  = 1'b0;
    end else begin
      id_pc_next_s    = pc_s;
      id_inst_next_s  = rom.rom_inst;
      id_valid_next_s = 1'b1;
      id_adel_next_s  = 1'b0;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc     <= ADDR_W'(ZERO_WORD);
      id_inst   <= DATA_W'(ZERO_WORD);
      id_valid  <= 1'b0;
      id_adel_r <= 1'b0;
    end else begin
      id_pc     <= id_pc_next_s;
      id_inst   <= id_inst_next_s;
      id_valid  <= id_valid_next_s;
      id_adel_r <= id_adel_next_s;
    end
  end

`ifdef INST_FETCH_ADEL_EN
  assign id_excp_adel = id_adel_r;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch; memory word at byte address A holds (A>>2)+1.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [1:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  int          checks;
  int          failures;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) rom_bus ();

  assign rom_bus.rom_inst = (rom_bus.rom_addr >> 2) + 32'd1;

  inst_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom             (rom_bus.master),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_valid        (id_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fl;
    logic [1:0]  st;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] iinst;
    logic        vld;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic [1:0] st, input logic br,
                              input logic [31:0] tgt, input logic [31:0] npc,
                              input logic [31:0] addr, input logic [31:0] ipc,
                              input logic [31:0] iinst, input logic vld);
    vec_t v;
    v.fl = fl; v.st = st; v.br = br; v.tgt = tgt; v.npc = npc;
    v.ce = 1'b1; v.addr = addr; v.ipc = ipc; v.iinst = iinst; v.vld = vld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ce, input logic [31:0] addr,
                         input logic [31:0] ipc, input logic [31:0] iinst, input logic vld);
    chk({nm, "_ce"},    {31'd0, rom_bus.rom_ce}, {31'd0, ce});
    chk({nm, "_addr"},  rom_bus.rom_addr, addr);
    chk({nm, "_idpc"},  id_pc, ipc);
    chk({nm, "_inst"},  id_inst, iinst);
    chk({nm, "_valid"}, {31'd0, id_valid}, {31'd0, vld});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    stall = 2'b00;
    flush = 1'b0;
    new_pc = 32'h0;
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;

    //           fl    st     br    tgt          npc           addr          idpc          inst          vld
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0004, 32'h0,        32'h1,        1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0008, 32'h4,        32'h2,        1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_000C, 32'h8,        32'h3,        1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h40,   32'h0,        32'h0000_0040, 32'hC,        32'h4,        1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0044, 32'h40,       32'h11,       1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0048, 32'h44,       32'h12,       1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h0000_0010, 32'h48,       32'h13,       1'b1));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h200,  32'h0,        32'h0000_0010, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0,    32'h0,        32'h0000_0010, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0014, 32'h10,       32'h5,        1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0018, 32'h14,       32'h6,        1'b1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0,    32'h0,        32'h0000_0018, 32'h14,       32'h6,        1'b1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0,    32'h0,        32'h0000_0018, 32'h14,       32'h6,        1'b1));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0,    32'h0,        32'h0000_0018, 32'h14,       32'h6,        1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_001C, 32'h18,       32'h7,        1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0020, 32'h1C,       32'h8,        1'b1));
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 32'h300,  32'h180,      32'h0000_0180, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0184, 32'h180,      32'h61,       1'b1));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0,    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 32'h4000_0000, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0004, 32'h0,        32'h1,        1'b1));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0,    32'h22,       32'h0000_0020, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,    32'h0,        32'h0000_0024, 32'h20,       32'h9,        1'b1));

    #2;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("boot", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      flush           = vecs[i].fl;
      stall           = vecs[i].st;
      branch_flag_i   = vecs[i].br;
      branch_target_i = vecs[i].tgt;
      new_pc          = vecs[i].npc;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].ce, vecs[i].addr, vecs[i].ipc,
              vecs[i].iinst, vecs[i].vld);
    end
    flush = 1'b0;
    stall = 2'b00;
    branch_flag_i = 1'b0;

    // Asynchronous reset in the middle of a cycle at pc=0x24.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("midrst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rsthold", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("reboot", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rerun0", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rerun1", 1'b1, 32'h4, 32'h0, 32'h1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
